// File: rtl/bfm_dut.sv
// bfm_dut: registered WIDTH-bit two-operand adder with a LATENCY-deep result pipeline.
// The operands are sampled on every rising edge. There is no handshake, enable or stall.
// The result is visible on res_o after edge N+LATENCY-1 for operands sampled at edge N.
// Optional build macro BFM_SAT_EN: overflowing sums clamp to all-ones instead of wrapping.
module bfm_dut #(
  parameter int WIDTH   = 8,
  parameter int LATENCY = 1
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [WIDTH-1:0] A_s,
  input  logic [WIDTH-1:0] B_s,
  output logic [WIDTH-1:0] res_o
);

  // Reject configurations the pipeline cannot be built for.
  generate
    if (LATENCY < 1 || LATENCY > 4) begin : g_bad_latency
      $error("bfm_dut: LATENCY=%0d outside legal range 1..4", LATENCY);
    end
    if (WIDTH < 1) begin : g_bad_width
      $error("bfm_dut: WIDTH=%0d must be at least 1", WIDTH);
    end
  endgenerate

`ifdef BFM_SAT_EN
  // The carry-out bit selects a clamp to the largest representable value.
  function automatic logic [WIDTH-1:0] sat_sum(input logic [WIDTH:0] s);
    return s[WIDTH] ? {WIDTH{1'b1}} : s[WIDTH-1:0];
  endfunction

  logic [WIDTH:0]   sum_p0;
`else
  // In wrap mode the carry is never observed, so only the low WIDTH bits are formed.
  logic [WIDTH-1:0] sum_p0;
`endif

  logic [WIDTH-1:0] pipe_d [LATENCY];
  logic [WIDTH-1:0] pipe_q [LATENCY];

  // Stage 0 input: the sum (clamped when saturating), then a plain shift toward res_o.
  always_comb begin
`ifdef BFM_SAT_EN
    sum_p0    = {1'b0, A_s} + {1'b0, B_s};
    pipe_d[0] = sat_sum(sum_p0);
`else
    sum_p0    = A_s + B_s;
    pipe_d[0] = sum_p0;
`endif
    for (int i = 1; i < LATENCY; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  // Pipeline registers. Reset clears every stage at once, so in-flight sums are dropped.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      pipe_q <= '{default: '0};
    end else begin
      pipe_q <= pipe_d;
    end
  end

  assign res_o = pipe_q[LATENCY-1];

endmodule

// File: tb/tb_bfm_dut.sv
// Bench for bfm_dut. Two instances share the operand bus: one with LATENCY=1 and one with LATENCY=3.
// Expected sums are queued per instance when operands are sampled and popped once per edge.
// The reference model honours BFM_SAT_EN in the same way as the design.
module tb_bfm_dut;

  logic       clk_i;
  logic       reset_i;
  logic [7:0] A_s;
  logic [7:0] B_s;
  logic [7:0] res1_o;
  logic [7:0] res3_o;

  int pass_cnt;
  int chk_cnt;

  logic [7:0] q1[$];
  logic [7:0] q3[$];

  bfm_dut #(.WIDTH(8), .LATENCY(1)) u_dut1 (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .A_s     (A_s),
    .B_s     (B_s),
    .res_o   (res1_o)
  );

  bfm_dut #(.WIDTH(8), .LATENCY(3)) u_dut3 (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .A_s     (A_s),
    .B_s     (B_s),
    .res_o   (res3_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  function automatic logic [7:0] model_sum(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, b};
`ifdef BFM_SAT_EN
    if (s[8]) return 8'hFF;
`endif
    return s[7:0];
  endfunction

  task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed 0x%02h expected 0x%02h", tag, obs, exp);
  endtask

  // Pipelines are empty after reset: the LATENCY=3 instance shows two zero results first.
  task automatic flush_model();
    q1 = {};
    q3 = {};
    q3.push_back(8'h00);
    q3.push_back(8'h00);
  endtask

  // Drive one operand pair, clock once, and check both instances just after the edge.
  task automatic cycle(input string tag, input logic [7:0] a, input logic [7:0] b);
    logic [7:0] e1;
    logic [7:0] e3;
    A_s = a;
    B_s = b;
    @(posedge clk_i);
    e1 = 8'h00;
    e3 = 8'h00;
    if (reset_i) begin
      q1.push_back(model_sum(a, b));
      q3.push_back(model_sum(a, b));
      e1 = q1.pop_front();
      e3 = q3.pop_front();
    end
    #1;
    check8({tag, "_lat1"}, res1_o, e1);
    check8({tag, "_lat3"}, res3_o, e3);
  endtask

  // Assert reset asynchronously between edges; outputs must clear before any edge.
  task automatic async_reset(input string tag);
    #2;
    reset_i = 1'b0;
    #1;
    check8({tag, "_lat1"}, res1_o, 8'h00);
    check8({tag, "_lat3"}, res3_o, 8'h00);
    flush_model();
  endtask

  initial begin
    pass_cnt = 0;
    chk_cnt  = 0;
    reset_i  = 1'b0;
    A_s      = 8'd5;
    B_s      = 8'd7;
    flush_model();

    // Reset held with operands present: the outputs stay cleared.
    #1;
    check8("reset_t0_lat1", res1_o, 8'h00);
    check8("reset_t0_lat3", res3_o, 8'h00);
    repeat (3) cycle("reset_hold", 8'd5, 8'd7);

    // Release: the first edge samples 5+7 normally.
    reset_i = 1'b1;
    cycle("first_after_reset", 8'd5, 8'd7);
    cycle("first_after_reset2", 8'd5, 8'd7);
    cycle("first_after_reset3", 8'd5, 8'd7);

    // Basic and back-to-back sums.
    cycle("basic_10_22", 8'h10, 8'h22);
    cycle("b2b_1_2", 8'd1, 8'd2);
    cycle("b2b_3_4", 8'd3, 8'd4);
    cycle("b2b_5_6", 8'd5, 8'd6);

    // Overflow corner cases.
    cycle("ovf_ff_02", 8'hFF, 8'h02);
    cycle("ovf_80_80", 8'h80, 8'h80);
    cycle("max_ff_00", 8'hFF, 8'h00);
    cycle("ovf_ff_ff", 8'hFF, 8'hFF);
    cycle("ovf_ff_01", 8'hFF, 8'h01);
    repeat (3) cycle("drain", 8'd0, 8'd0);

    // One-cycle pulse through the deeper pipeline, with zeros on either side.
    cycle("pulse_9_1", 8'd9, 8'd1);
    repeat (4) cycle("pulse_tail", 8'd0, 8'd0);

    // Constant operands yield a constant result once the pipeline fills.
    repeat (5) cycle("const_33_44", 8'h33, 8'h44);

    // Random stream interrupted by an asynchronous reset.
    for (int i = 0; i < 1000; i++) begin
      cycle("stream", 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    end
    async_reset("midreset_async");
    cycle("midreset_hold", 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    reset_i = 1'b1;
    for (int i = 0; i < 50; i++) begin
      cycle("post_reset", 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    end

    // Soak: random bursts separated by brief resets.
    for (int burst = 0; burst < 20; burst++) begin
      for (int i = 0; i < 1000; i++) begin
        cycle("soak", 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
      end
      async_reset("soak_reset");
      cycle("soak_reset_hold", 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
      reset_i = 1'b1;
    end
    repeat (4) cycle("final_drain", 8'd0, 8'd0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
